// File: rtl/adda_pkg.sv
// rtl/adda_pkg.sv - shared ADC/FIFO constants, capture FSM states and log2 helper
package adda_pkg;

  // Native ADC sample width; also the write-data width of the capture FIFO.
  localparam int ADDA_DATA_WIDTH = 14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } capt_state_e;

  // log2 of a power-of-two decimation factor; a bounded loop keeps it usable
  // as a constant function for any factor up to 2**31.
  function automatic int log2_pow2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/decim_accum.sv
// rtl/decim_accum.sv - DECIM-sample accumulator with group-complete strobe
module decim_accum
  import adda_pkg::*;
#(
  parameter int DATA_WIDTH = ADDA_DATA_WIDTH,
  parameter int DECIM      = 4,
  localparam int LOG2_DECIM = log2_pow2(DECIM),
  localparam int ACC_W      = DATA_WIDTH + LOG2_DECIM
) (
  input  logic                  clk_a,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  smp_vld_i,
  input  logic [DATA_WIDTH-1:0] smp_data_i,
  output logic [ACC_W-1:0]      grp_sum_o,
  output logic                  grp_vld_o
);

  // A 1-bit counter is kept for DECIM=1 so the vector never collapses to zero width.
  localparam int CNT_W = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             grp_vld_q, grp_vld_d;
  logic [ACC_W-1:0] acc_next;
  logic             last_smp;

  assign acc_next = acc_q + ACC_W'(smp_data_i);
  assign last_smp = (cnt_q == CNT_W'(DECIM - 1));

  // Accumulate valid samples; the DECIMth sample closes the group and restarts the sum.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    grp_vld_d = 1'b0;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (smp_vld_i) begin
      if (last_smp) begin
        sum_d     = acc_next;
        grp_vld_d = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = acc_next;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Accumulator, sample counter and group result registers.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      grp_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      grp_vld_q <= grp_vld_d;
    end
  end

  assign grp_sum_o = sum_q;
  assign grp_vld_o = grp_vld_q;

endmodule

// File: rtl/adc_sample_writer.sv
// rtl/adc_sample_writer.sv - decimating ADC capture into a FIFO with back-pressure drop count
module adc_sample_writer
  import adda_pkg::*;
#(
  parameter int DATA_WIDTH = ADDA_DATA_WIDTH,
  parameter int DECIM      = 4,
  parameter int FRAME_LEN  = 64
) (
  input  logic                  clk_a,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic                  adc_otr,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  fifo_full,
  input  logic                  fifo_almst_full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           drop_cnt,
  output logic                  ovr_flag
);

  localparam int LOG2_DECIM = log2_pow2(DECIM);
  localparam int ACC_W      = DATA_WIDTH + LOG2_DECIM;

  capt_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] adc_q;
  logic                  smp_vld_q;
  logic [15:0]           grp_cnt_q, grp_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic                  ovr_q, ovr_d;

  logic [ACC_W-1:0]      grp_sum;
  logic                  grp_vld;
  logic                  accum_clr;
  logic                  grp_ok;
  logic                  grp_last;
  logic                  back_pressure;
  logic                  start_acc;

  // Outside CAPTURE, or on an abort, any partial group is thrown away. A group whose
  // strobe is already up at the abort edge is still written, so done never leads it.
  assign accum_clr     = (state_q != ST_CAPTURE) || stop;
  assign grp_ok        = grp_vld && (state_q == ST_CAPTURE);
  assign grp_last      = grp_ok && (grp_cnt_q == 16'(FRAME_LEN - 1));
  assign back_pressure = fifo_full || fifo_almst_full;
  assign start_acc     = (state_q == ST_IDLE) && start;

  // Input register; a sample belongs to the frame if it was registered in CAPTURE.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      adc_q     <= '0;
      smp_vld_q <= 1'b0;
    end else begin
      adc_q     <= adc_data;
      smp_vld_q <= (state_q == ST_CAPTURE);
    end
  end

  decim_accum #(
    .DATA_WIDTH (DATA_WIDTH),
    .DECIM      (DECIM)
  ) u_accum (
    .clk_a      (clk_a),
    .rst        (rst),
    .clr_i      (accum_clr),
    .smp_vld_i  (smp_vld_q),
    .smp_data_i (adc_q),
    .grp_sum_o  (grp_sum),
    .grp_vld_o  (grp_vld)
  );

  // Capture FSM next state: frame ends on abort or when the last group lands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_CAPTURE;
      ST_CAPTURE: if (stop || grp_last) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Per-group write/drop decision, frame group count and sticky out-of-range flag.
  always_comb begin
    grp_cnt_d  = grp_cnt_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    drop_cnt_d = drop_cnt_q;
    ovr_d      = ovr_q;
    if (start_acc) begin
      grp_cnt_d  = '0;
      drop_cnt_d = '0;
      ovr_d      = 1'b0;
    end
    if ((state_q == ST_CAPTURE) && adc_otr) begin
      ovr_d = 1'b1;
    end
    if (grp_ok) begin
      // Dropped groups still advance the frame: the frame is a fixed time window.
      grp_cnt_d = grp_cnt_q + 16'd1;
      if (!back_pressure) begin
        wr_en_d   = 1'b1;
        wr_data_d = DATA_WIDTH'(grp_sum >> LOG2_DECIM);
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grp_cnt_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      drop_cnt_q <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grp_cnt_q  <= grp_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      drop_cnt_q <= drop_cnt_d;
      ovr_q      <= ovr_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q == ST_CAPTURE);
  assign done     = (state_q == ST_DONE);
  assign drop_cnt = drop_cnt_q;
  assign ovr_flag = ovr_q;

endmodule

// File: tb/tb_adc_sample_writer.sv
// tb/tb_adc_sample_writer.sv - directed self-checking bench for adc_sample_writer
module tb_adc_sample_writer;

  localparam int DW = 14;
  localparam int NK = 46;

  logic          clk_a = 1'b0;
  logic          rst;
  logic [DW-1:0] adc_data;
  logic          adc_otr;
  logic          start;
  logic          stop;
  logic          fifo_full;
  logic          fifo_almst_full;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic [15:0]   drop_cnt;
  logic          ovr_flag;

  int n_checks = 0;
  int n_errors = 0;

  logic          obs_wr   [NK];
  logic          obs_busy [NK];
  logic          obs_done [NK];
  logic          obs_ovr  [NK];
  logic [DW-1:0] obs_data [NK];
  logic [15:0]   obs_drop [NK];

  int       n_wr, n_done, done_k, last_wr_k, bad_data, bad_pos;
  logic [7:0] wr_mask;

  always #5 clk_a = ~clk_a;

  adc_sample_writer #(
    .DATA_WIDTH (DW),
    .DECIM      (4),
    .FRAME_LEN  (8)
  ) dut (
    .clk_a           (clk_a),
    .rst             (rst),
    .adc_data        (adc_data),
    .adc_otr         (adc_otr),
    .start           (start),
    .stop            (stop),
    .fifo_full       (fifo_full),
    .fifo_almst_full (fifo_almst_full),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .busy            (busy),
    .done            (done),
    .drop_cnt        (drop_cnt),
    .ovr_flag        (ovr_flag)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rst = 1'b0; start = 1'b0; stop = 1'b0; adc_otr = 1'b0;
    fifo_full = 1'b0; fifo_almst_full = 1'b0; adc_data = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_a); #1;
    end
  endtask

  // Index j = inputs sampled at edge E0+j; obs[j] = outputs just after that edge.
  task automatic run(input bit ramp, input int af_lo, input int af_hi, input int ff_lo,
                     input int ff_hi, input int stop_at, input int otr_at, input int rst_at,
                     input int start2_at);
    for (int j = 0; j < NK; j++) begin
      start           = (j == 0) || (j == start2_at);
      stop            = (j == stop_at);
      adc_otr         = (j == otr_at);
      rst             = (j == rst_at);
      fifo_almst_full = (j >= af_lo) && (j <= af_hi);
      fifo_full       = (j >= ff_lo) && (j <= ff_hi);
      adc_data        = ramp ? DW'((j - 1) & 3) : 14'h1000;
      @(posedge clk_a); #1;
      obs_wr[j]   = wr_en;
      obs_busy[j] = busy;
      obs_done[j] = done;
      obs_ovr[j]  = ovr_flag;
      obs_data[j] = wr_data;
      obs_drop[j] = drop_cnt;
    end
    idle(3);
  endtask

  // Group n is expected to be written right after edge E0+4n+6.
  task automatic analyse(input logic [DW-1:0] exp_data);
    n_wr = 0; n_done = 0; done_k = -1; last_wr_k = -1; bad_data = 0; bad_pos = 0; wr_mask = '0;
    for (int k = 0; k < NK; k++) begin
      if (obs_wr[k]) begin
        n_wr++;
        last_wr_k = k;
        if (obs_data[k] !== exp_data) bad_data++;
        if (k < 6 || k > 34 || ((k - 6) % 4) != 0) bad_pos++;
        else wr_mask[(k - 6) / 4] = 1'b1;
      end
      if (obs_done[k]) begin
        n_done++;
        done_k = k;
      end
    end
  endtask

  task automatic check_frame(input string name, input logic [DW-1:0] exp_data,
                             input logic [7:0] exp_mask, input int exp_ndone,
                             input int exp_done_k, input logic [15:0] exp_drop);
    analyse(exp_data);
    check_eq({name, "_wr_mask"}, 32'(wr_mask), 32'(exp_mask));
    check_eq({name, "_wr_count"}, n_wr, $countones(exp_mask));
    check_eq({name, "_wr_data_bad"}, bad_data, 0);
    check_eq({name, "_wr_pos_bad"}, bad_pos, 0);
    check_eq({name, "_done_count"}, n_done, exp_ndone);
    check_eq({name, "_done_cycle"}, done_k, exp_done_k);
    if (exp_ndone > 0) check_eq({name, "_done_after_wr"}, 32'(done_k >= last_wr_k), 1);
    check_eq({name, "_drop_cnt"}, obs_drop[NK-1], exp_drop);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; stop = 1'b0; adc_otr = 1'b1;
    fifo_full = 1'b0; fifo_almst_full = 1'b0; adc_data = 14'h3FFF;
    repeat (3) @(posedge clk_a);
    #1;
    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_drop_cnt", drop_cnt, 0);
    check_eq("rst_ovr_flag", ovr_flag, 0);

    idle(2);
    stop = 1'b1;
    @(posedge clk_a); #1;
    stop = 1'b0;
    check_eq("idle_stop_busy", busy, 0);
    check_eq("idle_stop_done", done, 0);
    idle(2);

    // Constant input, full frame.
    run(1'b0, -1, -1, -1, -1, -1, -1, -1, -1);
    check_frame("const", 14'h1000, 8'hFF, 1, 34, 16'd0);
    check_eq("const_busy_k0", obs_busy[0], 1);
    check_eq("const_busy_k35", obs_busy[35], 0);
    check_eq("const_wr_data_hold", obs_data[NK-1], 14'h1000);
    check_eq("const_ovr", obs_ovr[NK-1], 0);

    // Ramp 0..3; stop together with start in IDLE must not block the capture.
    run(1'b1, -1, -1, -1, -1, 0, -1, -1, -1);
    check_frame("ramp", 14'd1, 8'hFF, 1, 34, 16'd0);
    check_eq("ramp_wr_data_hold", obs_data[NK-1], 14'd1);

    // Almost-full across the decisions for groups 3 and 4; a mid-frame start is ignored.
    run(1'b0, 17, 23, -1, -1, -1, -1, -1, 24);
    check_frame("almst", 14'h1000, 8'hE7, 1, 34, 16'd2);

    // Abort two samples into group 2.
    run(1'b0, -1, -1, -1, -1, 11, -1, -1, -1);
    check_frame("stop", 14'h1000, 8'h03, 1, 11, 16'd0);
    check_eq("stop_busy_k10", obs_busy[10], 1);
    check_eq("stop_busy_k11", obs_busy[11], 0);

    // Out-of-range sample inside group 1.
    run(1'b0, -1, -1, -1, -1, -1, 6, -1, -1);
    check_frame("otr", 14'h1000, 8'hFF, 1, 34, 16'd0);
    check_eq("otr_ovr_before", obs_ovr[5], 0);
    check_eq("otr_ovr_after", obs_ovr[6], 1);
    check_eq("otr_ovr_frame_end", obs_ovr[NK-1], 1);

    // Reset during group 5 (starting clears the sticky flag first).
    run(1'b0, -1, -1, -1, -1, -1, -1, 22, -1);
    check_eq("rstmid_ovr_cleared", obs_ovr[0], 0);
    check_frame("rstmid", 14'h1000, 8'h0F, 0, -1, 16'd0);
    check_eq("rstmid_busy", obs_busy[22], 0);
    check_eq("rstmid_wr_en", obs_wr[22], 0);
    check_eq("rstmid_wr_data", obs_data[22], 0);

    // A fresh frame after the reset runs all eight groups.
    run(1'b0, -1, -1, -1, -1, -1, -1, -1, -1);
    check_frame("after_rst", 14'h1000, 8'hFF, 1, 34, 16'd0);

    // FIFO full for the whole frame: every group dropped, frame still ends on time.
    run(1'b0, -1, -1, 0, NK, -1, -1, -1, -1);
    check_frame("full", 14'h1000, 8'h00, 1, 34, 16'd8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_sample_writer.md
ADC_SAMPLE_WRITER -- requirements
Module: adc_sample_writer

Interface
REQ-001 Parameter DATA_WIDTH, 14, ADC sample width; SHALL equal FIFO write-data width.
REQ-002 Parameter DECIM, 4, samples averaged per output word; SHALL be a power of two, 1..64.
REQ-003 Parameter FRAME_LEN, 64, decimated groups per capture frame; SHALL be 1..65535.
REQ-004 clk_a  in  1  ADC sample clock and FIFO write clock; all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high, on clk_a.
REQ-006 adc_data  in  DATA_WIDTH  unsigned raw ADC sample, valid every clk_a cycle.
REQ-007 adc_otr  in  1  ADC out-of-range flag, aligned with adc_data.
REQ-008 start  in  1  single-cycle capture request.
REQ-009 stop  in  1  single-cycle abort request.
REQ-010 fifo_full  in  1  downstream FIFO full.
REQ-011 fifo_almst_full  in  1  downstream FIFO almost full.
REQ-012 wr_en  out  1  one-cycle FIFO write strobe.
REQ-013 wr_data  out  DATA_WIDTH  averaged sample, valid when wr_en=1.
REQ-014 busy  out  1  high in CAPTURE.
REQ-015 done  out  1  one-cycle frame-end pulse.
REQ-016 drop_cnt  out  16  saturating count of groups dropped due to back-pressure.
REQ-017 ovr_flag  out  1  sticky out-of-range indicator.

Function
REQ-018 FSM states IDLE, CAPTURE, DONE; IDLE->CAPTURE on start; CAPTURE->DONE on stop or FRAME_LEN-th group completed; DONE->IDLE unconditionally next cycle.
REQ-019 start seen at edge E0: adc_data registered at edges E0+1..E0+DECIM forms group 0; each subsequent DECIM edges form the next group, no gaps.
REQ-020 Pipeline: input register, accumulator (width DATA_WIDTH+log2(DECIM)), output register; wr_en for group n high during the cycle after edge E0+(n+1)*DECIM+2.
REQ-021 wr_data SHALL be accumulator sum logically shifted right by log2(DECIM) (truncation, no rounding).
REQ-022 Group complete with fifo_full=0 and fifo_almst_full=0 -> wr_en=1; otherwise wr_en=0 and drop_cnt increments, holding at 16'hFFFF.
REQ-023 Dropped groups SHALL count toward FRAME_LEN (frame is time-defined).
REQ-024 done SHALL pulse in the DONE cycle, coinciding with or after the final wr_en, never before.
REQ-025 stop in CAPTURE: partial group discarded, no wr_en for it; already-complete groups in the pipeline still written.
REQ-026 start while CAPTURE or DONE ignored; stop in IDLE ignored; start and stop same cycle in IDLE -> capture starts.
REQ-027 adc_otr=1 on any sample registered in CAPTURE sets ovr_flag; ovr_flag and drop_cnt clear on accepted start.
REQ-028 wr_en SHALL never assert outside a frame's groups; wr_data holds last written value between writes.

Reset
REQ-029 rst=1: state IDLE; wr_en, busy, done, ovr_flag = 0; wr_data, drop_cnt, accumulator, group/sample counters = 0.
REQ-030 rst mid-capture: abandon frame immediately, no further wr_en, no done pulse.
REQ-031 rst has priority over start, stop and all inputs.

Structure
REQ-032 Package adda_pkg holds DATA_WIDTH default, FSM state enum, decimation log2 constant helper, shared with FIFO.
REQ-033 Sub-module decim_accum: accumulator plus sample counter, outputs group sum and group-complete strobe; FSM and back-pressure logic in top.

Verification (DECIM=4, FRAME_LEN=8)
REQ-034 Constant adc_data=14'h1000, start -> 8 wr_en pulses spaced 4 cycles, wr_data=14'h1000, first wr_en after edge E0+6, then one done pulse.
REQ-035 Ramp 0,1,2,3 repeating -> every wr_data=14'd1 (sum 6>>2).
REQ-036 fifo_almst_full high during groups 3 and 4 -> 6 writes, drop_cnt=2, done at same time as REQ-034.
REQ-037 stop 2 cycles into group 2 -> 2 writes, no partial write, done pulse, busy falls.
REQ-038 adc_otr pulse at group 1 -> ovr_flag=1 through frame end; cleared by next start.
REQ-039 rst asserted at group 5 -> outputs to reset values next edge, no done, next start runs full 8-group frame.
